apb_master_bridge: RTL

- APB initiator (requester) that converts a simple valid/ready command stream into APB3/APB4 transfers.
- Drives the same PSELx/PENABLE/PWRITE/PADDR/PWDATA/PSTRB bus that our APB slaves (e.g. the GPIO slave) respond on.
- Returns each transfer's outcome (read data, slave error, timeout) on a valid/ready response channel.
- One transfer outstanding at a time; a wait-state watchdog aborts transfers to hung slaves.

---
 rtl/apb_master_bridge_if.sv | 53 +++++
 rtl/apb_master_bridge.sv | 89 ++++++++
 2 files changed

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus bundle for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the
// environment's view (command producer, response consumer and APB slave).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB bus
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester: turns a valid/ready command stream into single APB
// transfers and reports each outcome (read data, slave error, watchdog
// timeout) on a valid/ready response channel. One transfer in flight.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_master_bridge_if.master   bus
);
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;

  // Commands are only taken while idle; no pipelining between transfers.
  assign bus.cmd_ready = (state == IDLE);

  // Transfer sequencer: APB phases, watchdog and registered response.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      bus.PSELx       <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.PSTRB       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.PSELx  <= 1'b1;
            bus.PWRITE <= bus.cmd_write;
            bus.PADDR  <= bus.cmd_addr;
            // reads drive neither data nor strobes
            bus.PWDATA <= bus.cmd_write ? bus.cmd_wdata : '0;
            bus.PSTRB  <= bus.cmd_write ? bus.cmd_strb  : '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          wd_cnt      <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // completion takes priority over a watchdog expiry on the same edge
          if (bus.PREADY) begin
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            state           <= RESP;
          end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            state           <= RESP;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
